// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state codes, default opcodes and instruction decode helper.
package jtag_pkg;

  localparam logic [3:0] TapCodeEx2Dr   = 4'h0;
  localparam logic [3:0] TapCodeEx1Dr   = 4'h1;
  localparam logic [3:0] TapCodeShDr    = 4'h2;
  localparam logic [3:0] TapCodePauseDr = 4'h3;
  localparam logic [3:0] TapCodeSelIr   = 4'h4;
  localparam logic [3:0] TapCodeUpDr    = 4'h5;
  localparam logic [3:0] TapCodeCapDr   = 4'h6;
  localparam logic [3:0] TapCodeSelDr   = 4'h7;
  localparam logic [3:0] TapCodeEx2Ir   = 4'h8;
  localparam logic [3:0] TapCodeEx1Ir   = 4'h9;
  localparam logic [3:0] TapCodeShIr    = 4'hA;
  localparam logic [3:0] TapCodePauseIr = 4'hB;
  localparam logic [3:0] TapCodeRti     = 4'hC;
  localparam logic [3:0] TapCodeUpIr    = 4'hD;
  localparam logic [3:0] TapCodeCapIr   = 4'hE;
  localparam logic [3:0] TapCodeTlr     = 4'hF;

  localparam int unsigned    DefaultIrWidth    = 3;
  localparam logic [2:0]     DefaultExtestCode = 3'b000;
  localparam logic [2:0]     DefaultSampleCode = 3'b001;

  typedef enum logic [3:0] {
    StEx2Dr   = TapCodeEx2Dr,
    StEx1Dr   = TapCodeEx1Dr,
    StShDr    = TapCodeShDr,
    StPauseDr = TapCodePauseDr,
    StSelIr   = TapCodeSelIr,
    StUpDr    = TapCodeUpDr,
    StCapDr   = TapCodeCapDr,
    StSelDr   = TapCodeSelDr,
    StEx2Ir   = TapCodeEx2Ir,
    StEx1Ir   = TapCodeEx1Ir,
    StShIr    = TapCodeShIr,
    StPauseIr = TapCodePauseIr,
    StRti     = TapCodeRti,
    StUpIr    = TapCodeUpIr,
    StCapIr   = TapCodeCapIr,
    StTlr     = TapCodeTlr
  } tap_state_e;

  // Anything that is neither EXTEST nor SAMPLE/PRELOAD routes through the bypass flop.
  function automatic logic is_bypass(input logic [31:0] ir, input logic [31:0] extest,
                                     input logic [31:0] sample);
    return !((ir == extest) || (ir == sample));
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller state register and TMS-driven next-state logic.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:     state_d = tms_i ? StTlr     : StRti;
      StRti:     state_d = tms_i ? StSelDr   : StRti;
      StSelDr:   state_d = tms_i ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms_i ? StEx1Dr   : StShDr;
      StShDr:    state_d = tms_i ? StEx1Dr   : StShDr;
      StEx1Dr:   state_d = tms_i ? StUpDr    : StPauseDr;
      StPauseDr: state_d = tms_i ? StEx2Dr   : StPauseDr;
      StEx2Dr:   state_d = tms_i ? StUpDr    : StShDr;
      StUpDr:    state_d = tms_i ? StSelDr   : StRti;
      StSelIr:   state_d = tms_i ? StTlr     : StCapIr;
      StCapIr:   state_d = tms_i ? StEx1Ir   : StShIr;
      StShIr:    state_d = tms_i ? StEx1Ir   : StShIr;
      StEx1Ir:   state_d = tms_i ? StUpIr    : StPauseIr;
      StPauseIr: state_d = tms_i ? StEx2Ir   : StPauseIr;
      StEx2Ir:   state_d = tms_i ? StUpIr    : StShIr;
      StUpIr:    state_d = tms_i ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller top: instruction/bypass registers, TDO mux and boundary-cell strobe decode.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned         IR_WIDTH    = DefaultIrWidth,
  parameter logic [IR_WIDTH-1:0] EXTEST_CODE = IR_WIDTH'(DefaultExtestCode),
  parameter logic [IR_WIDTH-1:0] SAMPLE_CODE = IR_WIDTH'(DefaultSampleCode)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSR_TDO,
  output logic                TDO,
  output logic                TDO_en,
  output logic                Shift_or_Load,
  output logic                Test_or_Normal,
  output logic                BSR_clock_en,
  output logic                BSR_update,
  output logic [3:0]          State,
  output logic [IR_WIDTH-1:0] IR
);

  localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(2'b01);

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic                bypass_q, bypass_d;
  logic                bsr_sel;
  logic                to_tlr;

  jtag_tap_fsm u_fsm (
    .clk_i   (Clock),
    .rst_ni  (Reset_n),
    .tms_i   (TMS),
    .state_o (state)
  );

  assign bsr_sel = !is_bypass(32'(ir_q), 32'(EXTEST_CODE), 32'(SAMPLE_CODE));
  // TLR is only reachable from TLR itself or Select-IR with TMS high.
  assign to_tlr  = TMS && ((state == StTlr) || (state == StSelIr));

  always_comb begin
    ir_d     = ir_q;
    ir_sr_d  = ir_sr_q;
    bypass_d = bypass_q;
    case (state)
      StCapIr: ir_sr_d = IrCapture;
      StShIr:  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
      StUpIr:  ir_d    = ir_sr_q;
      StCapDr: if (!bsr_sel) bypass_d = 1'b0;
      StShDr:  if (!bsr_sel) bypass_d = TDI;
      default: ;
    endcase
    if (to_tlr) begin
      ir_d = '1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ir_q     <= '1;
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
    end
  end

  always_comb begin
    TDO            = 1'b0;
    TDO_en         = 1'b0;
    Shift_or_Load  = 1'b0;
    BSR_clock_en   = 1'b0;
    BSR_update     = 1'b0;
    Test_or_Normal = (ir_q == EXTEST_CODE);
    case (state)
      StShIr: begin
        TDO    = ir_sr_q[0];
        TDO_en = 1'b1;
      end
      StShDr: begin
        TDO           = bsr_sel ? BSR_TDO : bypass_q;
        TDO_en        = 1'b1;
        Shift_or_Load = bsr_sel;
        BSR_clock_en  = bsr_sel;
      end
      StCapDr: BSR_clock_en = bsr_sel;
      StUpDr:  BSR_update   = bsr_sel;
      default: ;
    endcase
  end

  assign State = state;
  assign IR    = ir_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: state walks, IR load, EXTEST/SAMPLE/bypass scans, reset.
module tb_jtag_tap_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tms, tdi, bsr_tdo;
  logic       tdo, tdo_en, sol, ton, bsr_ce, bsr_upd;
  logic [3:0] state;
  logic [2:0] ir;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_tap_controller dut (
    .Clock          (clk),
    .Reset_n        (rst_n),
    .TMS            (tms),
    .TDI            (tdi),
    .BSR_TDO        (bsr_tdo),
    .TDO            (tdo),
    .TDO_en         (tdo_en),
    .Shift_or_Load  (sol),
    .Test_or_Normal (ton),
    .BSR_clock_en   (bsr_ce),
    .BSR_update     (bsr_upd),
    .State          (state),
    .IR             (ir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge clk);
    #1;
  endtask

  // From RTI: shift an opcode LSB first, update, return to RTI.
  task automatic load_ir(input logic [2:0] code);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 3; i++) tick(i == 2, code[i]);
    tick(1, 0);
    tick(0, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tdo"},    32'(tdo),     0);
    check({tag, "_tdo_en"}, 32'(tdo_en),  0);
    check({tag, "_sol"},    32'(sol),     0);
    check({tag, "_ton"},    32'(ton),     0);
    check({tag, "_ce"},     32'(bsr_ce),  0);
    check({tag, "_upd"},    32'(bsr_upd), 0);
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_tdo;

    rst_n = 1'b0; tms = 1'b1; tdi = 1'b0; bsr_tdo = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'hF);
    check("rst_ir", 32'(ir), 32'h7);
    check_quiet("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("tlr_hold", 32'(state), 32'hF);
    tick(0, 0);
    check("rti", 32'(state), 32'hC);

    // IR load of EXTEST with captured pattern shifted out
    tick(1, 0); check("seldr", 32'(state), 32'h7);
    tick(1, 0); check("selir", 32'(state), 32'h4);
    tick(0, 0); check("capir", 32'(state), 32'hE);
    tick(0, 0); check("shir", 32'(state), 32'hA);
    check("ir_tdo0", 32'(tdo), 1);
    check("ir_tdo_en", 32'(tdo_en), 1);
    tick(0, 0); check("ir_tdo1", 32'(tdo), 0);
    tick(0, 0); check("ir_tdo2", 32'(tdo), 0);
    tick(1, 0); check("ex1ir", 32'(state), 32'h9);
    check("ex1ir_tdo_en", 32'(tdo_en), 0);
    tick(1, 0); check("upir", 32'(state), 32'hD);
    check("upir_ir_old", 32'(ir), 32'h7);
    tick(0, 0); check("ir_extest", 32'(ir), 32'h0);
    check("ton_extest", 32'(ton), 1);

    // EXTEST DR scan of 4 cells
    pat = 4'b1011;
    tick(1, 0);
    tick(0, 0); check("capdr", 32'(state), 32'h6);
    check("capdr_ce", 32'(bsr_ce), 1);
    check("capdr_sol", 32'(sol), 0);
    tick(0, 0); check("shdr", 32'(state), 32'h2);
    for (int i = 0; i < 4; i++) begin
      bsr_tdo = pat[i];
      #1;
      check("ext_tdo", 32'(tdo), 32'(pat[i]));
      check("ext_ce", 32'(bsr_ce), 1);
      check("ext_sol", 32'(sol), 1);
      tick(i == 3, 0);
    end
    check("ex1dr", 32'(state), 32'h1);
    check("ex1dr_ce", 32'(bsr_ce), 0);
    tick(1, 0); check("updr", 32'(state), 32'h5);
    check("updr_upd", 32'(bsr_upd), 1);
    tick(0, 0); check("post_upd", 32'(bsr_upd), 0);
    check("post_upd_state", 32'(state), 32'hC);

    // Five TMS=1 from RTI
    repeat (5) tick(1, 0);
    check("tms5_rti", 32'(state), 32'hF);
    check("tms5_ir", 32'(ir), 32'h7);
    check("tms5_ton", 32'(ton), 0);
    tick(0, 0);

    // Bypass through undefined opcode
    load_ir(3'b101);
    check("ir_101", 32'(ir), 32'h5);
    pat = 4'b1101;      // TDI order 1,0,1,1 (LSB first)
    exp_tdo = 4'b1010;  // TDO order 0,1,0,1
    tick(1, 0);
    tick(0, 0); check("byp_capdr_ce", 32'(bsr_ce), 0);
    tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      check("byp_tdo", 32'(tdo), 32'(exp_tdo[i]));
      check("byp_ce", 32'(bsr_ce), 0);
      tick(i == 3, pat[i]);
    end
    tick(1, 0); check("byp_upd", 32'(bsr_upd), 0);
    tick(0, 0);

    // SAMPLE with Pause/Exit2 loop
    load_ir(3'b001);
    check("ir_sample", 32'(ir), 32'h1);
    check("ton_sample", 32'(ton), 0);
    tick(1, 0); tick(0, 0); tick(0, 0);
    check("smp_sol", 32'(sol), 1);
    tick(0, 0); tick(1, 0); tick(0, 0);
    check("pausedr", 32'(state), 32'h3);
    check_quiet("pause");
    tick(0, 0); check("pause_hold", 32'(state), 32'h3);
    tick(1, 0); check("ex2dr", 32'(state), 32'h0);
    tick(0, 0); check("reshdr", 32'(state), 32'h2);
    check("reshdr_sol", 32'(sol), 1);
    check("reshdr_ton", 32'(ton), 0);
    bsr_tdo = 1'b1; #1;
    check("reshdr_tdo", 32'(tdo), 1);
    tick(1, 0); tick(1, 0);
    check("smp_upd", 32'(bsr_upd), 1);
    tick(0, 0);

    // Five TMS=1 from Shift-IR discards the partial shift
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    check("shir2", 32'(state), 32'hA);
    repeat (5) tick(1, 1);
    check("tms5_shir", 32'(state), 32'hF);
    check("tms5_shir_ir", 32'(ir), 32'h7);
    tick(0, 0);

    // Asynchronous reset mid Shift-DR under EXTEST
    load_ir(3'b000);
    tick(1, 0); tick(0, 0); tick(0, 0);
    bsr_tdo = 1'b1;
    tick(0, 1);
    check("pre_rst_sol", 32'(sol), 1);
    check("pre_rst_ton", 32'(ton), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'hF);
    check("arst_ir", 32'(ir), 32'h7);
    check_quiet("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tms = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rti", 32'(state), 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
